// File: rtl/stack_judge.sv
// Placement judge: ANDs the dropped row with the surviving row below. Result pulse two cycles
// after the press edge, then idle on the third. Presses arriving while busy are dropped, not queued.
module stack_judge #(
  parameter int COLS       = 8,
  parameter int LEVELS     = 15,
  parameter int INIT_WIDTH = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            place,
  input  logic [COLS-1:0] row_mask,
  output logic            next_signal,
  output logic            fail,
  output logic            win,
  output logic [3:0]      level,
  output logic [COLS-1:0] base_mask,
  output logic [3:0]      width,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EVAL, REPORT} state_t;

  localparam logic [3:0] LAST_LEVEL = 4'(LEVELS);
  localparam logic [3:0] INIT_W     = 4'(INIT_WIDTH);

  function automatic logic [3:0] popcount(input logic [COLS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  state_t          state;
  logic            place_q;
  logic [COLS-1:0] cap;
  logic [COLS-1:0] ovl;
  logic [COLS-1:0] hit;
  logic [3:0]      cnt;

  assign hit = cap & base_mask;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      place_q     <= 1'b0;
      cap         <= '0;
      ovl         <= '0;
      cnt         <= '0;
      next_signal <= 1'b0;
      fail        <= 1'b0;
      win         <= 1'b0;
      level       <= 4'd1;
      base_mask   <= '1;
      width       <= INIT_W;
      busy        <= 1'b0;
    end else begin
      place_q     <= place;
      next_signal <= 1'b0;
      fail        <= 1'b0;
      win         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (place && !place_q) begin
            cap   <= row_mask;
            busy  <= 1'b1;
            state <= EVAL;
          end
        end
        EVAL: begin
          // Pulses are registered here so they are visible for the whole REPORT cycle.
          ovl         <= hit;
          cnt         <= popcount(hit);
          fail        <= (hit == '0);
          next_signal <= (hit != '0);
          win         <= (hit != '0) && (level == LAST_LEVEL);
          state       <= REPORT;
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (ovl == '0 || level == LAST_LEVEL) begin
            level     <= 4'd1;
            base_mask <= '1;
            width     <= INIT_W;
          end else begin
            level     <= level + 4'd1;
            base_mask <= ovl;
            width     <= cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_judge.sv
// Scoreboarded bench for stack_judge: driver pushes expected outcomes, monitor checks pulses.
module tb_stack_judge;

  logic       clk = 1'b0;
  logic       resetn;
  logic       place;
  logic [7:0] row_mask;
  logic       next_signal, fail, win, busy;
  logic [3:0] level, width;
  logic [7:0] base_mask;

  always #5 clk = ~clk;

  stack_judge #(.COLS(8), .LEVELS(15), .INIT_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn), .place(place), .row_mask(row_mask),
    .next_signal(next_signal), .fail(fail), .win(win), .level(level),
    .base_mask(base_mask), .width(width), .busy(busy)
  );

  typedef struct {
    logic       nxt;
    logic       fl;
    logic       wn;
    int         lvl;
    logic [7:0] base;
    int         wid;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Game model: where the tower stands after every judged drop
  int         m_level;
  logic [7:0] m_base;
  int         m_width;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_level = 1;
    m_base  = 8'hff;
    m_width = 3;
  endfunction

  function automatic void model_drop(input logic [7:0] m);
    exp_t       e;
    logic [7:0] ov;
    ov = m & m_base;
    e.nxt = (ov != 0);
    e.fl  = (ov == 0);
    e.wn  = (ov != 0) && (m_level == 15);
    if (ov == 0 || m_level == 15) begin
      model_reset();
    end else begin
      m_level = m_level + 1;
      m_base  = ov;
      m_width = $countones(ov);
    end
    e.lvl  = m_level;
    e.base = m_base;
    e.wid  = m_width;
    q.push_back(e);
  endfunction

  // Caller is one cycle past an edge with place low. hold: extra cycles place stays high;
  // poke: re-raise place while the judgement is still in progress.
  task automatic press(input logic [7:0] m, input int hold, input bit poke);
    row_mask = m;
    place    = 1'b1;
    model_drop(m);
    @(posedge clk); #1;
    chk("busy_eval", busy, 1);
    if (hold == 0) place = 1'b0;
    @(posedge clk); #1;
    chk("busy_report", busy, 1);
    if (poke) place = 1'b1;
    @(posedge clk); #1;
    chk("busy_done", busy, 0);
    if (hold > 0) repeat (hold) begin @(posedge clk); #1; end
    if (poke || hold > 0) begin
      place = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (next_signal === 1'b1 || fail === 1'b1 || win === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got next=%b fail=%b win=%b expected no pulse",
                 next_signal, fail, win);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("next_signal", next_signal, e.nxt);
        chk("fail", fail, e.fl);
        chk("win", win, e.wn);
        @(negedge clk);
        chk("pulse_one_cycle", {next_signal, fail, win}, 0);
        chk("level", level, e.lvl);
        chk("base_mask", base_mask, e.base);
        chk("width", width, e.wid);
      end
    end
  end

  initial begin
    resetn   = 1'b0;
    place    = 1'b0;
    row_mask = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 1);
    chk("rst_base", base_mask, 8'hff);
    chk("rst_width", width, 3);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {next_signal, fail, win}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Narrowing sequence then a miss
    press(8'b00011100, 0, 0);
    press(8'b00111000, 0, 0);
    press(8'b11000000, 0, 0);

    // Long hold and a re-press while busy: one judgement each
    press(8'b00001111, 10, 0);
    press(8'b00000110, 0, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("hold_no_extra", q.size(), 0);

    // Force back to level 1, then climb all the way to a win
    press(8'h00, 0, 0);
    for (int i = 0; i < 15; i++) press(8'b00011100, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("after_win_level", level, 1);

    // Reset in the EVAL cycle must suppress the result
    press(8'b01100000, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    row_mask = 8'b01000000;
    place    = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    place  = 1'b0;
    @(posedge clk); #1;
    chk("midrst_level", level, 1);
    chk("midrst_base", base_mask, 8'hff);
    chk("midrst_width", width, 3);
    chk("midrst_busy", busy, 0);
    resetn = 1'b1;
    model_reset();
    repeat (5) begin @(posedge clk); #1; end

    // Random drops, biased toward overlapping the current base
    for (int i = 0; i < 300; i++) begin
      logic [7:0] m;
      int         sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) m = 8'h00;
      else if (sel == 1) m = 8'($urandom);
      else if (sel < 4) m = m_base << $urandom_range(0, 1);
      else m = m_base >> $urandom_range(0, 1);
      press(m, (($urandom_range(0, 9) == 0) ? 2 : 0), ($urandom_range(0, 7) == 0));
    end

    repeat (6) begin @(posedge clk); #1; end
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
